// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and FSM encodings for the
// memory-mapped UART.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int unsigned ST_RX_VALID   = 0;
    localparam int unsigned ST_TX_FULL    = 1;
    localparam int unsigned ST_TX_IDLE    = 2;
    localparam int unsigned ST_RX_OVERRUN = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic logic [15:0] status_word(input logic rx_valid,
                                                input logic tx_full,
                                                input logic tx_idle,
                                                input logic rx_overrun);
        logic [15:0] w;
        w                = '0;
        w[ST_RX_VALID]   = rx_valid;
        w[ST_TX_FULL]    = tx_full;
        w[ST_TX_IDLE]    = tx_idle;
        w[ST_RX_OVERRUN] = rx_overrun;
        return w;
    endfunction

endpackage

// File: rtl/bus_uart_fifo.sv
// Transmit FIFO: power-of-two depth, extra pointer bit separates full from empty.
// Read data is the current head; a push into an empty FIFO is visible next cycle.
module bus_uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // A push while full is accepted only when the head leaves on the same edge.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/bus_uart.sv
// 16-bit CPU bus UART: DATA/STATUS registers, buffered 8N1 transmitter,
// single-byte receiver with overrun flag and level interrupt.
module bus_uart #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned TX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        rw,
    input  logic        lds_n,
    input  logic [1:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        dtack_n,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    import uart_pkg::*;

    localparam int unsigned     CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- bus interface ----------------
    logic        r_cs_d;
    logic        r_dtack_n;
    logic [15:0] r_dout;
    logic        w_start;
    logic        w_rd_data;
    logic        w_wr_data;
    logic [15:0] w_rdata;
    logic        w_unused_din;

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [7:0]  w_fifo_data;
    logic        w_tx_pop;
    logic        w_tx_idle;

    logic [7:0]  r_rx_byte;
    logic        r_rx_valid;
    logic        r_rx_overrun;

    assign w_unused_din = &{1'b0, din[15:8]};

    assign w_start   = cs & ~r_cs_d;
    assign w_rd_data = w_start & rw & (addr == REG_DATA);
    assign w_wr_data = w_start & ~rw & (addr == REG_DATA) & ~lds_n;

    always_comb begin
        w_rdata = '0;
        case (addr)
            REG_DATA:   w_rdata = {8'h00, r_rx_byte};
            REG_STATUS: w_rdata = status_word(r_rx_valid, w_fifo_full,
                                              w_tx_idle, r_rx_overrun);
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cs_d    <= 1'b0;
            r_dtack_n <= 1'b1;
            r_dout    <= '0;
        end else begin
            r_cs_d    <= cs;
            r_dtack_n <= ~cs;
            if (w_start) r_dout <= w_rdata;
        end
    end

    assign dout    = r_dout;
    assign dtack_n = r_dtack_n;

    // ---------------- transmitter ----------------
    bus_uart_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_wr_data),
        .i_data  (din[7:0]),
        .i_pop   (w_tx_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    tx_state_t     r_tx_state, w_tx_state_n;
    logic [CW-1:0] r_tx_cnt,   w_tx_cnt_n;
    logic [2:0]    r_tx_bit,   w_tx_bit_n;
    logic [7:0]    r_tx_shift, w_tx_shift_n;
    logic          r_tx;
    logic          w_tx_n;

    assign w_tx_idle = w_fifo_empty & (r_tx_state == TX_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx       <= w_tx_n;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_pop     = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_fifo_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_shift_n = w_fifo_data;
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_state_n = TX_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + CW'(1);
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) w_tx_state_n = TX_STOP;
                    else                  w_tx_bit_n   = r_tx_bit + 3'd1;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + CW'(1);
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_n = '0;
                    // Chain straight into the next start bit so queued bytes leave gap-free.
                    if (!w_fifo_empty) begin
                        w_tx_pop     = 1'b1;
                        w_tx_shift_n = w_fifo_data;
                        w_tx_state_n = TX_START;
                    end else begin
                        w_tx_state_n = TX_IDLE;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + CW'(1);
                end
            end
            default: w_tx_state_n = TX_IDLE;
        endcase

        // Line level is registered from the next state to keep uart_tx glitch-free.
        case (w_tx_state_n)
            TX_START: w_tx_n = 1'b0;
            TX_DATA:  w_tx_n = w_tx_shift_n[0];
            default:  w_tx_n = 1'b1;
        endcase
    end

    assign uart_tx = r_tx;

    // ---------------- receiver ----------------
    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_prev;
    rx_state_t     r_rx_state, w_rx_state_n;
    logic [CW-1:0] r_rx_cnt,   w_rx_cnt_n;
    logic [2:0]    r_rx_bit,   w_rx_bit_n;
    logic [7:0]    r_rx_shift, w_rx_shift_n;
    logic          w_rx_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
        end
    end

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_done    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_cnt_n   = '0;
                    w_rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_n = '0;
                    w_rx_bit_n = '0;
                    w_rx_state_n = r_rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
                    else                  w_rx_bit_n   = r_rx_bit + 3'd1;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + CW'(1);
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_done    = r_rx_s2;
                    w_rx_state_n = RX_IDLE;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + CW'(1);
                end
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

    // A read on the completion edge consumes the old byte, so the new one is not an overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_byte    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else if (w_rx_done) begin
            r_rx_byte    <= r_rx_shift;
            r_rx_valid   <= 1'b1;
            r_rx_overrun <= (r_rx_overrun | r_rx_valid) & ~w_rd_data;
        end else if (w_rd_data) begin
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end
    end

    assign irq = r_rx_valid;

endmodule
